fifo_reader: RTL and testbench

//  Read-side controller for the team's 8-bit, 16-deep synchronous FIFO (en_read/data_out/underflow).

---
 rtl/fifo_reader.sv | 129 ++++++++++++
 tb/tb_fifo_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Read-side controller for the 8-bit/16-deep synchronous FIFO: shadow occupancy,
// guarded read strobes, and a 2-entry skid buffer feeding a valid/ready stream.
module fifo_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_accept,
  output logic             en_read,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             underflow,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    level,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    level_q, level_d;
  logic             err_q, err_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       held_q, held_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             valid_q, valid_d;

  logic             pop;
  logic             overrun;
  logic             new_err;
  logic [1:0]       held_free;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      level_q    <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      held_q     <= '0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      held_q     <= held_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      valid_q    <= valid_d;
    end
  end

  // Read issue, shadow count, error FSM and skid buffer next-state
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    err_d      = err_q;
    inflight_d = 1'b0;
    held_d     = held_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    valid_d    = valid_q;
    pop        = 1'b0;
    overrun    = 1'b0;
    new_err    = 1'b0;
    held_free  = '0;
    en_read    = 1'b0;

    pop       = valid_q & m_ready;
    // A word leaving the skid on this edge frees its slot for the next read.
    held_free = held_q - 2'(pop);
    en_read   = ~reset & (state_q == RUN) & (level_q != '0)
              & ((held_free + 2'(inflight_q)) < 2'd2);
    inflight_d = en_read;

    overrun = wr_accept & (level_q == CW'(DEPTH)) & ~en_read;
    if (!overrun) begin
      level_d = level_q + CW'(wr_accept) - CW'(en_read);
    end

    new_err = underflow | overrun;
    if (new_err) begin
      err_d   = 1'b1;
      state_d = HALT;
    end else if (err_clr) begin
      err_d   = 1'b0;
      state_d = RUN;
    end

    case ({inflight_q, pop})
      2'b10: begin
        if (held_q == 2'd0) slot0_d = fifo_data;
        else                slot1_d = fifo_data;
        held_d = held_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        held_d  = held_q - 2'd1;
      end
      2'b11: begin
        if (held_q == 2'd1) begin
          slot0_d = fifo_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = fifo_data;
        end
      end
      default: ;
    endcase
    valid_d = (held_d != 2'd0);
  end

  assign m_data  = slot0_q;
  assign m_valid = valid_q;
  assign level   = level_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized scoreboard bench for fifo_reader: a queue-based FIFO model supplies read data,
// expected words are queued on write and popped by a monitor on every downstream beat.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_accept;
  logic [7:0] wdata;
  logic       en_read;
  logic [7:0] fifo_data;
  logic       underflow;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       err;
  logic       err_clr;

  fifo_reader #(.WIDTH(8), .DEPTH(16), .CW(5)) dut (
    .clk(clk), .reset(reset), .wr_accept(wr_accept), .en_read(en_read),
    .fifo_data(fifo_data), .underflow(underflow), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .level(level), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       err_exp = 1'b0;
  int         cyc = 0;
  int         beats = 0;
  int         rd_cnt = 0;
  int         first_beat = -1;
  int         last_beat = -1;

  logic       s_wr = 1'b0, s_rd = 1'b0, s_uf = 1'b0, s_clr = 1'b0, s_rst = 1'b1;
  logic [7:0] s_wdata = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO plus error expectation, advanced on the edge using values sampled mid-cycle
  always @(posedge clk) begin
    logic ovr;
    cyc++;
    if (s_rst) begin
      fifo_q.delete();
      exp_q.delete();
      err_exp = 1'b0;
      fifo_data <= '0;
    end else begin
      if (s_rd && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      ovr = s_wr && (fifo_q.size() == 16);
      if (s_wr && !ovr) begin
        fifo_q.push_back(s_wdata);
        exp_q.push_back(s_wdata);
      end
      if (s_uf || ovr) err_exp = 1'b1;
      else if (s_clr)  err_exp = 1'b0;
    end
  end

  // Monitor: invariant checks and scoreboard pops on every transfer
  always @(negedge clk) begin
    if (!reset) begin
      chk("level", 32'(level), 32'(fifo_q.size()));
      chk("err", 32'(err), 32'(err_exp));
      if (fifo_q.size() == 0) chk("read_when_empty", 32'(en_read), 32'd0);
      if (err_exp) chk("read_when_halted", 32'(en_read), 32'd0);
      if (prev_stall) chk("hold_data", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        beats++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        if (exp_q.size() == 0) chk("stale_word", 32'(m_data), 32'hFFFF_FFFF);
        else chk("data_order", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (en_read) rd_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
    s_wr    = wr_accept;
    s_wdata = wdata;
    s_rd    = en_read;
    s_uf    = underflow;
    s_clr   = err_clr;
    s_rst   = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_accept = 1'b1;
    wdata     = d;
    step();
    wr_accept = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    m_ready = 1'b1;
    while ((level != '0 || m_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", 32'(n < budget), 32'd1);
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, r0;
    logic [7:0] head;
    reset = 1'b1; wr_accept = 1'b0; wdata = '0; underflow = 1'b0;
    m_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_en_read", 32'(en_read), 32'd0);
    reset = 1'b0;
    step();

    // 16 back-to-back random writes, consumer always ready
    m_ready = 1'b1;
    b0 = beats; first_beat = -1;
    for (int i = 0; i < 16; i++) write_word(8'($urandom));
    drain(60);
    chk("t1_beats", 32'(beats - b0), 32'd16);
    chk("t1_back_to_back", 32'(last_beat - first_beat), 32'd15);

    // Stalled consumer: two reads fill the skid, then three consecutive beats
    m_ready = 1'b0;
    r0 = rd_cnt;
    write_word(8'hA5); write_word(8'h3C); write_word(8'h7E);
    repeat (4) step();
    chk("t2_read_pulses", 32'(rd_cnt - r0), 32'd2);
    chk("t2_level", 32'(level), 32'd1);
    chk("t2_m_valid", 32'(m_valid), 32'd1);
    chk("t2_head", 32'(m_data), 32'hA5);
    b0 = beats;
    m_ready = 1'b1;
    repeat (3) step();
    chk("t2_consecutive", 32'(beats - b0), 32'd3);
    drain(20);

    // Read and write in the same cycle at level 1
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_word(8'($urandom));
      chk("t3_level_one", 32'(level), 32'd1);
    end
    drain(20);

    // Overrun: 18 writes reach level 16 with reads blocked, the 19th overruns
    m_ready = 1'b0;
    b0 = beats;
    head = 8'($urandom);
    write_word(head);
    for (int i = 1; i < 19; i++) write_word(8'($urandom));
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_level_sat", 32'(level), 32'd16);
    chk("t4_en_read", 32'(en_read), 32'd0);
    chk("t4_head", 32'(m_data), 32'(head));
    repeat (3) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_err_cleared", 32'(err), 32'd0);
    drain(80);
    chk("t4_beats", 32'(beats - b0), 32'd18);

    // Underflow halts reads, skid still drains, simultaneous clear loses
    m_ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    repeat (4) step();
    underflow = 1'b1; step(); underflow = 1'b0;
    chk("t5_err", 32'(err), 32'd1);
    m_ready = 1'b1;
    repeat (4) step();
    chk("t5_skid_drained", 32'(beats - b0), 32'd2);
    chk("t5_level_held", 32'(level), 32'd2);
    err_clr = 1'b1; underflow = 1'b1; step(); underflow = 1'b0;
    chk("t5_err_wins", 32'(err), 32'd1);
    step(); err_clr = 1'b0;
    chk("t5_err_cleared", 32'(err), 32'd0);
    drain(20);
    chk("t5_beats", 32'(beats - b0), 32'd4);

    // Reset with a skid word held and a read in flight
    m_ready = 1'b0;
    wr_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin wdata = 8'($urandom); step(); end
    wr_accept = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_en_read", 32'(en_read), 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    b0 = beats;
    repeat (6) step();
    chk("t6_no_stale", 32'(beats - b0), 32'd0);
    for (int i = 0; i < 3; i++) write_word(8'($urandom));
    drain(20);
    chk("t6_beats", 32'(beats - b0), 32'd3);

    // Random traffic
    b0 = beats;
    for (int i = 0; i < 400; i++) begin
      wr_accept = (level < 5'd15) && ($urandom_range(0, 2) != 0);
      wdata     = 8'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    wr_accept = 1'b0;
    drain(80);
    chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
